data_memory_unit: RTL
=====================

Name: data_memory_unit

Overview:
- Responder side of the pipeline's memory interface: the data memory that the Memory stage drives with read/write requests, and that returns load data to it.
- Holds a word-addressed 16-bit RAM with a configurable multi-cycle read latency and a ready/valid handshake.
- Reports misaligned or illegal requests.
- Sits between the Memory stage (request initiator) and the writeback mux (consumer of loadData).

Parameters:
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W 16-bit words
READ_LAT, 2, clock edges from read acceptance to response (legal range 1..15)
DATA_W, 16, data word width (fixed at 16 for this ISA)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  read request, level, held until accepted
MemWrite  input  1  write request, level, held until accepted
Addr  input  16  byte address (ALU result); bit 0 must be 0
StoreData  input  16  write data
Ready  output  1  unit can accept a request this cycle
loadData  output  16  read data, valid only while LoadValid=1
LoadValid  output  1  one-cycle read-response strobe
MemErr  output  1  one-cycle error strobe

Behaviour:
- Handshake: accept = Ready & (MemRead | MemWrite), sampled at a rising edge. The requester drops or changes its request in the cycle after acceptance; a request held longer is re-accepted.
- Word index: Addr[ADDR_W:1]. Addr[15:ADDR_W+1] are ignored, so addresses alias (wrap) modulo 2**(ADDR_W+1) bytes.
- States: IDLE, BUSY. Ready = (state==IDLE), registered.
- Write accepted in IDLE: RAM updated at the accepting edge; state stays IDLE; Ready stays 1; no response. A read accepted on the next edge returns the new value (no stale read).
- Read accepted in IDLE at edge E0:
  - State goes to BUSY and Ready falls at E0; the latency counter loads READ_LAT-1.
  - The counter decrements each edge in BUSY.
  - At edge E0+READ_LAT: LoadValid=1, loadData=RAM word (as of E0), state returns to IDLE, Ready=1.
  - At E0+READ_LAT+1: LoadValid=0.
  - Maximum throughput is one read per READ_LAT+1 cycles.
  - READ_LAT=1: BUSY lasts exactly one cycle.
- loadData holds its last value when LoadValid=0. Consumers must gate on LoadValid.
- Misaligned request (Addr[0]=1):
  - Write: RAM is not modified; MemErr pulses at the cycle after the accepting edge.
  - Read: normal timing, but loadData=16'h0000 and MemErr=1 coincident with LoadValid.
- MemRead & MemWrite both high when accepted: treated as a write (subject to the misalignment rule); MemErr pulses the next cycle; no read response.
- Requests while Ready=0 are ignored; no queuing.
- Reset (async, active-low), asserted at any time including mid-read:
  - Outputs forced immediately: state=IDLE, counter=0, Ready=1 (from the first edge after release), LoadValid=0, loadData=16'h0000, MemErr=0.
  - Any in-flight read is discarded; no late LoadValid after release.
  - RAM contents are not cleared and remain undefined until written.
- While reset is low: Ready=0.

Decomposition:
- Shared package: state enum {IDLE, BUSY}, DATA_W constant, latency-counter width (4 bits), address-LSB helper function.
- One sub-module: data_ram. Single-port synchronous RAM, write-first on write, registered read. It has no reset on the array.
- The top level holds the FSM, counter, error logic and the output registers.

Test Plan:
- Reset: hold reset=0 with MemRead=1, Addr=16'h0004 -> Ready=0, LoadValid=0, loadData=0, MemErr=0; after release Ready=1 by the first edge.
- Write then read: write 16'hAAAA at Addr 16'h0004, next cycle read 16'h0004 (READ_LAT=2) -> Ready low 2 cycles, LoadValid one cycle exactly 2 edges after acceptance, loadData=16'hAAAA, MemErr=0.
- Aliasing: write 16'h1234 at 16'h0202 (ADDR_W=8), read 16'h0002 -> loadData=16'h1234.
- Misaligned: write 16'h5555 at 16'h0011 -> MemErr pulse, then read 16'h0010 returns prior value; read 16'h0011 -> LoadValid with loadData=0 and MemErr=1.
- Illegal and busy: MemRead=MemWrite=1 at 16'h0008 with data 16'h00FF -> word written, MemErr pulses, no LoadValid; a write presented during BUSY is not performed until Ready=1.
- Reset mid-read: accept a read, assert reset one cycle later -> no LoadValid ever for that read; Ready=1 after release; RAM still holds 16'hAAAA at 16'h0004.

Source files
------------

// File: rtl/data_memory_unit_pkg.sv
// Shared types and constants for the data memory unit.
package data_memory_unit_pkg;

  localparam int unsigned DMU_DATA_W = 16;
  localparam int unsigned DMU_LAT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmu_state_t;

  // A request is misaligned when the byte address is odd.
  function automatic logic addr_misaligned(input logic [15:0] addr);
    return (addr & 16'h0001) != 16'h0000;
  endfunction

endpackage

// File: rtl/data_memory_unit_data_ram.sv
// Single-port synchronous RAM: write-first, registered read, no array reset.
module data_ram
  import data_memory_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = DMU_DATA_W
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Enabled access: write updates the array and the read port, else read.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_unit.sv
// Data memory responder: ready/valid request handshake, multi-cycle reads,
// misaligned / conflicting request error reporting.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned DATA_W   = DMU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] StoreData,
  output logic              Ready,
  output logic [DATA_W-1:0] loadData,
  output logic              LoadValid,
  output logic              MemErr
);

  dmu_state_t             r_state;
  logic [DMU_LAT_W-1:0]   r_cnt;
  logic                   r_ready;
  logic                   r_load_valid;
  logic [DATA_W-1:0]      r_load_data;
  logic                   r_mem_err;
  logic                   r_rd_mis;

  dmu_state_t             w_state_nxt;
  logic [DMU_LAT_W-1:0]   w_cnt_nxt;
  logic                   w_load_valid_nxt;
  logic [DATA_W-1:0]      w_load_data_nxt;
  logic                   w_mem_err_nxt;
  logic                   w_rd_mis_nxt;

  logic                   w_accept;
  logic                   w_mis;
  logic                   w_ram_en;
  logic                   w_ram_we;
  logic [ADDR_W-1:0]      w_word_idx;
  logic [DATA_W-1:0]      w_ram_rdata;

  assign w_accept   = r_ready & (MemRead | MemWrite);
  assign w_mis      = addr_misaligned(Addr);
  // Upper address bits drop out here, so byte addresses wrap modulo 2**(ADDR_W+1).
  assign w_word_idx = ADDR_W'(Addr >> 1);
  // Writes take priority over reads; a misaligned write never touches the array.
  assign w_ram_we   = w_accept & MemWrite & ~w_mis;
  assign w_ram_en   = w_accept & ~(MemWrite & w_mis);

  data_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_word_idx),
    .i_wdata (StoreData),
    .o_rdata (w_ram_rdata)
  );

  // Next-state, latency counter and response/error values.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_load_valid_nxt = 1'b0;
    w_load_data_nxt  = r_load_data;
    w_mem_err_nxt    = 1'b0;
    w_rd_mis_nxt     = r_rd_mis;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (MemWrite) begin
            w_mem_err_nxt = w_mis | MemRead;
          end else begin
            w_state_nxt  = BUSY;
            w_cnt_nxt    = DMU_LAT_W'(READ_LAT - 1);
            w_rd_mis_nxt = w_mis;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt      = IDLE;
          w_load_valid_nxt = 1'b1;
          w_load_data_nxt  = r_rd_mis ? '0 : w_ram_rdata;
          w_mem_err_nxt    = r_rd_mis;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; Ready stays low through reset and rises one edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_mem_err    <= 1'b0;
      r_rd_mis     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ready      <= (w_state_nxt == IDLE);
      r_load_valid <= w_load_valid_nxt;
      r_load_data  <= w_load_data_nxt;
      r_mem_err    <= w_mem_err_nxt;
      r_rd_mis     <= w_rd_mis_nxt;
    end
  end

  assign Ready     = r_ready;
  assign loadData  = r_load_data;
  assign LoadValid = r_load_valid;
  assign MemErr    = r_mem_err;

endmodule
